// File: rtl/pool_pkg.sv
// pool_pkg: shared types and constants for the 2x2 pooling controller.
// Holds the FSM state enum, window timing constant and a counter-width helper.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAST,
        POOL,
        WRITE,
        DONE
    } pool_state_e;

    // FETCH x4, LAST, POOL, WRITE
    localparam int CYCLES_PER_WIN = 7;

    // Width of a counter that must hold 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_ctrl_if.sv
// pool_ctrl_if: memory and pooling-unit bus of the pooling controller.
// master = controller (read/write ports, window pixels, pool strobe);
// slave = memories + pooling unit (rd_data, pool_out).
interface pool_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        in1;
    logic [7:0]        in2;
    logic [7:0]        in3;
    logic [7:0]        in4;
    logic              pool_en;
    logic [7:0]        pool_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output in1, in2, in3, in4, pool_en,
        input  pool_out,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  in1, in2, in3, in4, pool_en,
        output pool_out,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: read/write address generation for one 2x2 window.
// In: window row/col, fetch index k (TL,TR,BL,BR). Out: rd_addr, wr_addr.
module pool_addr_gen #(
    parameter int IMG_W  = 28,
    parameter int ADDR_W = 10,
    parameter int WR_W   = 4,
    parameter int WC_W   = 4
) (
    input  logic [WR_W-1:0]   win_r,
    input  logic [WC_W-1:0]   win_c,
    input  logic [1:0]        k,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    // k[1] selects the bottom row, k[0] the right column of the window,
    // so {win, k bit} is 2*win + offset without an adder.
    always_comb begin
        row     = ADDR_W'({win_r, k[1]});
        col     = ADDR_W'({win_c, k[0]});
        rd_addr = row * ADDR_W'(IMG_W) + col;
        wr_addr = ADDR_W'(win_r) * ADDR_W'(IMG_W / 2) + ADDR_W'(win_c);
    end

endmodule

// File: rtl/pool_ctrl.sv
// pool_ctrl: walks an IMG_W x IMG_H map in 2x2 windows, fetches 4 pixels,
// strobes the pooling unit and writes one result per window.
// Ports: clk, rst (async, active-high), start, busy, done; bus = memory
// read/write ports, window pixels in1..in4, pool_en / pool_out.
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    pool_ctrl_if.master bus
);

    localparam int WR_W = cnt_w(IMG_H / 2);
    localparam int WC_W = cnt_w(IMG_W / 2);

    pool_state_e       st;
    pool_state_e       nxt;
    logic [1:0]        k;
    logic [WR_W-1:0]   win_r;
    logic [WC_W-1:0]   win_c;
    logic [7:0]        px_tl;
    logic [7:0]        px_tr;
    logic [7:0]        px_bl;
    logic [7:0]        px_br;
    logic              rd_en;
    logic              pool_en;
    logic              wr_en;
    logic              last_c;
    logic              last_r;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;

    assign last_c = (win_c == WC_W'(IMG_W / 2 - 1));
    assign last_r = (win_r == WR_W'(IMG_H / 2 - 1));

    pool_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W),
        .WR_W   (WR_W),
        .WC_W   (WC_W)
    ) u_addr (
        .win_r   (win_r),
        .win_c   (win_c),
        .k       (k),
        .rd_addr (ra),
        .wr_addr (wa)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    always_comb begin
        nxt     = st;
        busy    = 1'b1;
        done    = 1'b0;
        rd_en   = 1'b0;
        pool_en = 1'b0;
        wr_en   = 1'b0;
        unique case (st)
            IDLE: begin
                busy = 1'b0;
                if (start) nxt = FETCH;
            end
            FETCH: begin
                rd_en = 1'b1;
                if (k == 2'd3) nxt = LAST;
            end
            LAST: nxt = POOL;
            POOL: begin
                pool_en = 1'b1;
                nxt     = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                nxt   = (last_c && last_r) ? DONE : FETCH;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Pixel capture lags its read by one cycle: read k lands during k+1,
    // and the BR read lands during LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k     <= '0;
            win_r <= '0;
            win_c <= '0;
            px_tl <= '0;
            px_tr <= '0;
            px_bl <= '0;
            px_br <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (start) begin
                        k     <= '0;
                        win_r <= '0;
                        win_c <= '0;
                    end
                end
                FETCH: begin
                    k <= k + 2'd1;
                    if (k == 2'd1) px_tl <= bus.rd_data;
                    if (k == 2'd2) px_tr <= bus.rd_data;
                    if (k == 2'd3) px_bl <= bus.rd_data;
                end
                LAST: px_br <= bus.rd_data;
                WRITE: begin
                    if (last_c) begin
                        win_c <= '0;
                        win_r <= last_r ? '0 : win_r + WR_W'(1);
                    end else begin
                        win_c <= win_c + WC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_en ? ra : '0;
    assign bus.in1     = px_tl;
    assign bus.in2     = px_tr;
    assign bus.in3     = px_bl;
    assign bus.in4     = px_br;
    assign bus.pool_en = pool_en;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_en ? wa : '0;
    assign bus.wr_data = wr_en ? bus.pool_out : '0;

endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: bench for pool_ctrl on a 4x4 and a 2x2 map, with memory and
// averaging pooling-unit models and a per-window reference of the writes.
module tb_pool_ctrl;

    typedef logic [7:0] mem_t [0:1023];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    logic busy1, done1, busy2, done2;

    int n_cmp = 0;
    int n_err = 0;
    int dc1 = 0;
    int dc2 = 0;
    logic pe1_q = 1'b0;
    logic pe2_q = 1'b0;

    mem_t mem1;
    mem_t mem2;
    logic [17:0] wq1[$];
    logic [17:0] wq2[$];
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    pool_ctrl_if #(.ADDR_W(10)) b1 ();
    pool_ctrl_if #(.ADDR_W(10)) b2 ();

    pool_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(10)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .busy  (busy1),
        .done  (done1),
        .bus   (b1.master)
    );

    pool_ctrl #(.IMG_W(2), .IMG_H(2), .ADDR_W(10)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .busy  (busy2),
        .done  (done2),
        .bus   (b2.master)
    );

    // Pooling unit under control: floor average of the four pixels.
    function automatic logic [7:0] avg4(input logic [7:0] a, b, c, d);
        logic [9:0] s;
        s = {2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d};
        return s[9:2];
    endfunction

    always @(posedge clk) begin
        if (b1.rd_en) b1.rd_data <= mem1[b1.rd_addr];
        if (b1.pool_en) b1.pool_out <= avg4(b1.in1, b1.in2, b1.in3, b1.in4);
        if (b2.rd_en) b2.rd_data <= mem2[b2.rd_addr];
        if (b2.pool_en) b2.pool_out <= avg4(b2.in1, b2.in2, b2.in3, b2.in4);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b1.wr_en) wq1.push_back({b1.wr_addr, b1.wr_data});
            if (b2.wr_en) wq2.push_back({b2.wr_addr, b2.wr_data});
            if (done1) dc1++;
            if (done2) dc2++;
            n_cmp++;
            if (int'(b1.rd_en) + int'(b1.pool_en) + int'(b1.wr_en) > 1) begin
                n_err++;
                $display("FAIL strobe_mutex1 rd/pool/wr=%b%b%b required at most one",
                         b1.rd_en, b1.pool_en, b1.wr_en);
            end
            n_cmp++;
            if (b1.pool_en && pe1_q) begin
                n_err++;
                $display("FAIL pool_en_twice1 got 2 consecutive required 1");
            end
            n_cmp++;
            if (int'(b2.rd_en) + int'(b2.pool_en) + int'(b2.wr_en) > 1) begin
                n_err++;
                $display("FAIL strobe_mutex2 rd/pool/wr=%b%b%b required at most one",
                         b2.rd_en, b2.pool_en, b2.wr_en);
            end
        end
        pe1_q <= b1.pool_en;
        pe2_q <= b2.pool_en;
    end

    a_strobes1: assert property (@(posedge clk) disable iff (rst)
        $onehot0({b1.rd_en, b1.pool_en, b1.wr_en}) &&
        !(b1.pool_en && $past(b1.pool_en)));

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1);
    end

    // Reference: every window's floor mean, written row-major to w/2-wide map.
    function automatic void build_exp(input mem_t m, input int w, input int h);
        int tl, s;
        exp_q.delete();
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                tl = 2 * r * w + 2 * c;
                s = int'(m[tl]) + int'(m[tl + 1]) + int'(m[tl + w]) + int'(m[tl + w + 1]);
                exp_q.push_back({10'(r * (w / 2) + c), 8'(s / 4)});
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pass1(input int extra, output int n);
        start1 = 1'b1;
        tick();
        n = 0;
        while (!done1 && n < 1000) begin
            if (n >= extra) start1 = 1'b0;
            tick();
            n++;
        end
        start1 = 1'b0;
        if (!done1) begin
            n_cmp++;
            n_err++;
            $display("FAIL pass1_timeout got no done required done");
        end
    endtask

    task automatic pass2(output int n);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 1000) begin
            tick();
            n++;
        end
        if (!done2) begin
            n_cmp++;
            n_err++;
            $display("FAIL pass2_timeout got no done required done");
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({busy1, done1, b1.rd_en, b1.rd_addr, b1.pool_en, b1.wr_en,
             b1.wr_addr, b1.wr_data} !== '0) begin
            n_err++;
            $display("FAIL reset_out1 got %b required 0",
                     {busy1, done1, b1.rd_en, b1.rd_addr, b1.pool_en, b1.wr_en,
                      b1.wr_addr, b1.wr_data});
        end
        n_cmp++;
        if ({b1.in1, b1.in2, b1.in3, b1.in4} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_px1 got %h required 0",
                     {b1.in1, b1.in2, b1.in3, b1.in4});
        end
        n_cmp++;
        if ({busy2, done2, b2.rd_en, b2.pool_en, b2.wr_en} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_out2 got %b required 0",
                     {busy2, done2, b2.rd_en, b2.pool_en, b2.wr_en});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL idle_busy got %b required 0", busy1);
        end
    endtask

    task automatic test_known_4x4();
        int n;
        logic [17:0] want [4];
        want[0] = {10'd0, 8'd2};
        want[1] = {10'd1, 8'd4};
        want[2] = {10'd2, 8'd10};
        want[3] = {10'd3, 8'd12};
        for (int i = 0; i < 16; i++) mem1[i] = 8'(i);
        wq1.delete();
        pass1(0, n);
        n_cmp++;
        if (n != 28) begin
            n_err++;
            $display("FAIL known_latency got %0d required 28", n);
        end
        n_cmp++;
        if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL done_busy got %b required 1", busy1);
        end
        tick();
        n_cmp++;
        if ({busy1, done1} !== 2'b00) begin
            n_err++;
            $display("FAIL after_done got %b required 00", {busy1, done1});
        end
        n_cmp++;
        if (wq1.size() != 4) begin
            n_err++;
            $display("FAIL known_count got %0d required 4", wq1.size());
        end
        for (int i = 0; i < 4 && i < wq1.size(); i++) begin
            n_cmp++;
            if (wq1[i] !== want[i]) begin
                n_err++;
                $display("FAIL known_write%0d got a=%0d d=%0d required a=%0d d=%0d",
                         i, wq1[i][17:8], wq1[i][7:0], want[i][17:8], want[i][7:0]);
            end
        end
    endtask

    task automatic test_random_4x4();
        int n;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++) mem1[i] = 8'($urandom);
            build_exp(mem1, 4, 4);
            wq1.delete();
            pass1(0, n);
            tick();
            n_cmp++;
            if (wq1.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL rand_count got %0d required %0d", wq1.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < wq1.size(); i++) begin
                n_cmp++;
                if (wq1[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_write%0d got %h required %h", i, wq1[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_small_2x2();
        int n;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 4; i++) mem2[i] = (it == 0) ? 8'hFF : 8'($urandom);
            build_exp(mem2, 2, 2);
            wq2.delete();
            pass2(n);
            n_cmp++;
            if (n != 7) begin
                n_err++;
                $display("FAIL small_latency got %0d required 7", n);
            end
            tick();
            n_cmp++;
            if (wq2.size() != 1 || wq2[0] !== exp_q[0]) begin
                n_err++;
                $display("FAIL small_write got n=%0d %h required n=1 %h",
                         wq2.size(), (wq2.size() > 0) ? wq2[0] : 18'h0, exp_q[0]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int n, d0;
        for (int i = 0; i < 16; i++) mem1[i] = 8'($urandom);
        build_exp(mem1, 4, 4);
        wq1.delete();
        d0 = dc1;
        pass1(int'($urandom_range(20, 5)), n);
        tick();
        n_cmp++;
        if (n != 28 || wq1.size() != 4 || dc1 - d0 != 1) begin
            n_err++;
            $display("FAIL start_ignored got cyc=%0d wr=%0d done=%0d required 28/4/1",
                     n, wq1.size(), dc1 - d0);
        end
        for (int i = 0; i < 4 && i < wq1.size(); i++) begin
            n_cmp++;
            if (wq1[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL ign_write%0d got %h required %h", i, wq1[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, pe;
        for (int i = 0; i < 16; i++) mem1[i] = 8'($urandom);
        build_exp(mem1, 4, 4);
        wq1.delete();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        pe = 0;
        n = 0;
        while (pe < 2 && n < 100) begin
            tick();
            n++;
            if (b1.pool_en) pe++;
        end
        n_cmp++;
        if (pe != 2) begin
            n_err++;
            $display("FAIL mid_reach got %0d pool strobes required 2", pe);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy1, done1, b1.rd_en, b1.rd_addr, b1.pool_en, b1.wr_en,
             b1.wr_addr, b1.wr_data, b1.in1, b1.in2, b1.in3, b1.in4} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_out got nonzero outputs required 0");
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (wq1.size() != 1 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_abandon got wr=%0d busy=%b required wr=1 busy=0",
                     wq1.size(), busy1);
        end
        wq1.delete();
        pass1(0, n);
        tick();
        n_cmp++;
        if (wq1.size() != 4) begin
            n_err++;
            $display("FAIL mid_rerun_count got %0d required 4", wq1.size());
        end
        for (int i = 0; i < 4 && i < wq1.size(); i++) begin
            n_cmp++;
            if (wq1[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL mid_write%0d got %h required %h", i, wq1[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, d0;
        for (int i = 0; i < 16; i++) mem1[i] = 8'($urandom);
        build_exp(mem1, 4, 4);
        wq1.delete();
        d0 = dc1;
        start1 = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            n = 0;
            while (!done1 && n < 200) begin
                tick();
                n++;
            end
            n_cmp++;
            if (n != 28) begin
                n_err++;
                $display("FAIL b2b_len%0d got %0d required 28", p, n);
            end
            if (p == 2) start1 = 1'b0;
            tick();
            n_cmp++;
            if ({busy1, b1.rd_en} !== 2'b00) begin
                n_err++;
                $display("FAIL b2b_idle%0d got busy/rd=%b required 00", p, {busy1, b1.rd_en});
            end
            if (p < 2) begin
                tick();
                n_cmp++;
                if ({busy1, b1.rd_en, b1.rd_addr} !== {2'b11, 10'd0}) begin
                    n_err++;
                    $display("FAIL b2b_restart%0d got busy=%b rd=%b a=%0d required 1 1 0",
                             p, busy1, b1.rd_en, b1.rd_addr);
                end
            end
        end
        tick();
        n_cmp++;
        if (wq1.size() != 12 || dc1 - d0 != 3 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_total got wr=%0d done=%0d busy=%b required 12/3/0",
                     wq1.size(), dc1 - d0, busy1);
        end
        for (int i = 0; i < 12 && i < wq1.size(); i++) begin
            n_cmp++;
            if (wq1[i] !== exp_q[i % 4]) begin
                n_err++;
                $display("FAIL b2b_write%0d got %h required %h", i, wq1[i], exp_q[i % 4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_4x4();
        test_random_4x4();
        test_small_2x2();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
